// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative multiply unit: FSM state encoding
// and the default operand width.
package mult_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mult_unit_abs.sv
// Conditional two's-complement magnitude: passes val_i through unless neg_i
// is set, in which case it returns -val_i modulo 2^WIDTH.
module mult_unit_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] mag_o
);

  always_comb begin
    mag_o = val_i;
    if (neg_i) begin
      mag_o = ~val_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier for mult/multu: WIDTH iterations on operand
// magnitudes, then a sign fix-up that commits the product to HI/LO.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_busy,
  output logic             mult_done
);

  mult_state_e        state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mplier_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     sum;

  mult_unit_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i (srca),
    .neg_i (mult_sign & srca[WIDTH-1]),
    .mag_o (mag_a)
  );

  mult_unit_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i (srcb),
    .neg_i (mult_sign & srcb[WIDTH-1]),
    .mag_o (mag_b)
  );

  mult_unit_abs #(.WIDTH(2*WIDTH)) u_abs_res (
    .val_i (acc_q),
    .neg_i (neg_q),
    .mag_o (result)
  );

  // {carry, acc, multiplier} shifted right as one register; after WIDTH steps
  // the full product sits in acc.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_d    = {sum, acc_q[WIDTH-1:1]};
    mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= result[2*WIDTH-1:WIDTH];
          lo_q    <= result[WIDTH-1:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          // IDLE, and the unused encoding recovers here as IDLE
          state_q <= IDLE;
          if (start_mult) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mult_busy = busy_q;
  assign mult_done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected products, a
// negedge monitor pops and compares on every mult_done pulse.
module tb_mult_unit;

  localparam int unsigned LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        mult_sign = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_busy;
  logic        mult_done;

  mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .srca       (srca),
    .srcb       (srcb),
    .hi         (hi),
    .lo         (lo),
    .mult_busy  (mult_busy),
    .mult_done  (mult_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] prod;
    int unsigned start;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [63:0] last = '0;
  int unsigned run = 0;
  int          passed = 0;
  int          total = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: product/latency on mult_done, HI/LO hold otherwise, busy width.
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (mult_done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got mult_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          check64("product", {hi, lo}, cur.prod);
          check_int("latency", int'(cyc - cur.start), int'(LAT));
          last = cur.prod;
        end
      end else begin
        check64("hold", {hi, lo}, last);
      end
      if (mult_busy) begin
        run++;
      end else if (run != 0) begin
        check_int("busy_len", int'(run), int'(LAT));
        run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the unit idle (or in its done cycle).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] prod);
    exp_t e;
    srca       = a;
    srcb       = b;
    mult_sign  = s;
    start_mult = 1'b1;
    e.prod     = prod;
    e.start    = cyc + 1;
    sb.push_back(e);
    step();
    start_mult = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!mult_done && n < 200) begin
      step();
      n++;
    end
    if (!mult_done) begin
      total++;
      $display("FAIL %s: got no mult_done expected pulse within 200 cycles", name);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [63:0] prod, input string name);
    issue(a, b, s, prod);
    wait_done(name);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check64("reset_hilo", {hi, lo}, 64'h0);
    check_int("reset_busy", int'(mult_busy), 0);
    check_int("reset_done", int'(mult_done), 0);
    reset = 1'b0;
    step();
    check_int("post_reset_busy", int'(mult_busy), 0);

    op(32'd7,          32'd6,          1'b0, 64'h0000_0000_0000_002A, "unsigned_basic");
    op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, "unsigned_max");
    op(32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "signed_mix");
    op(32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, "signed_min");
    op(32'h0000_0000,  32'hFFFF_FFFB,  1'b1, 64'h0, "zero_signed");

    // Start while busy is dropped; start in the done cycle is accepted.
    issue(32'd2, 32'd3, 1'b0, 64'd6);
    repeat (8) step();
    srca = 32'd9;
    srcb = 32'd9;
    start_mult = 1'b1;
    step();
    start_mult = 1'b0;
    wait_done("busy_protect_first");
    issue(32'd9, 32'd9, 1'b0, 64'h51);
    wait_done("busy_protect_second");
    step();

    // Operands wiggle after accept; the sampled values must win.
    issue(32'hFFFF_FFF0, 32'h0000_0100, 1'b1, 64'hFFFF_FFFF_FFFF_F000);
    repeat (12) begin
      srca      = $urandom;
      srcb      = $urandom;
      mult_sign = 1'($urandom_range(0, 1));
      step();
    end
    wait_done("operand_change");
    step();

    // Reset mid-operation aborts with no done pulse.
    issue(32'h1234, 32'h10, 1'b0, 64'h1_2340);
    repeat (13) step();
    reset = 1'b1;
    sb.delete();
    last = '0;
    #1;
    check64("midreset_hilo", {hi, lo}, 64'h0);
    check_int("midreset_busy", int'(mult_busy), 0);
    check_int("midreset_done", int'(mult_done), 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    check_int("after_abort_busy", int'(mult_busy), 0);
    op(32'd2, 32'd2, 1'b0, 64'd4, "after_reset");

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        step();
        n++;
      end
      if (sb.size() != 0) begin
        total++;
        $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multiply unit for the pipelined MIPS core, sitting directly downstream of the controller.
- Consumes the controller's start_mult and mult_sign strobes together with the execute-stage operands.
- Computes a 64-bit product over multiple cycles using radix-2 shift-add, then commits it to the HI/LO registers.
- Exposes busy/done so the hazard unit can stall mfhi/mflo and back-to-back mult/multu.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start_mult  input  1  from controller, one-cycle request to begin a multiply.
- mult_sign  input  1  from controller; 1 = mult (signed), 0 = multu.
- srca  input  WIDTH  rs operand, execute stage.
- srcb  input  WIDTH  rt operand, execute stage.
- hi  output  WIDTH  HI register, upper half of the last committed product.
- lo  output  WIDTH  LO register, lower half of the last committed product.
- mult_busy  output  1  high while an operation is in flight.
- mult_done  output  1  one-cycle pulse in the first cycle new hi/lo are visible.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset is asserted: state=IDLE, hi=0, lo=0, mult_busy=0, mult_done=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, FIX.
- IDLE, start_mult=1 at edge E0:
  - Latch multiplicand and multiplier magnitudes. If mult_sign=1 and the operand MSB=1, latch the two's-complement magnitude; otherwise latch the raw operand.
  - Latch neg = mult_sign & (srca[MSB] ^ srcb[MSB]).
  - Clear the 2*WIDTH accumulator; set counter=WIDTH.
  - Go to RUN; mult_busy=1 from the cycle after E0.
- RUN, each edge:
  - If multiplier LSB=1, add the multiplicand into the accumulator upper half, with carry.
  - Shift {carry, accumulator, multiplier} right by 1; decrement counter.
  - When counter reaches 0, i.e. after exactly WIDTH steps at edges E1..E_WIDTH, go to FIX.
- FIX, edge E_{WIDTH+1}:
  - {hi,lo} <= neg ? -accumulator : accumulator, taken mod 2^(2*WIDTH).
  - mult_done=1 and mult_busy=0 for the following cycle; state returns to IDLE.
- Latency: start at E0 to new hi/lo visible after E_{WIDTH+1}, i.e. 33 edges for WIDTH=32.
- hi/lo hold the previous result for the whole operation; they update only in FIX.
- start_mult while RUN or FIX: ignored. The hazard unit must stall on mult_busy; the block does not queue requests.
- start_mult in the mult_done cycle: accepted, because state is IDLE. mult_busy rises the next cycle and hi/lo keep the just-committed value.
- mult_sign, srca and srcb are sampled only at accept; later changes have no effect.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as an unsigned WIDTH-bit value, so there is no overflow. (-2^31)*(-2^31) = 0x4000_0000_0000_0000.
- Zero operand: still takes the full latency; result 0, and neg has no effect on zero.
- Reset mid-operation: aborts immediately, hi/lo clear to 0, and no mult_done pulse is produced.
- Post-reset requirement: mult_busy must not glitch high.

Decomposition:
- Shared package/include (mips_defs):
  - State encodings IDLE=2'd0, RUN=2'd1, FIX=2'd2; value 3 is illegal and decodes to IDLE.
  - Default WIDTH.
- One natural sub-module, mult_abs: combinational WIDTH-bit conditional two's-complement magnitude.
  - Instantiated twice for the operands.
  - Reused in FIX at 2*WIDTH via its WIDTH parameter.
- Control FSM and the accumulator datapath stay in mult_unit.

Test Plan:
- Unsigned basic: srca=7, srcb=6, mult_sign=0, start pulse -> after 33 edges hi=0, lo=0x2A, mult_done one cycle, mult_busy high for exactly 33 cycles.
- Unsigned max: 0xFFFFFFFF * 0xFFFFFFFF, multu -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed mix: -3 (0xFFFFFFFD) * 5, mult -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then 0x80000000 * 0x80000000 signed -> hi=0x40000000, lo=0.
- Busy protection: start 2*3. Pulse start with 9*9 at cycle 10 -> ignored, result hi=0, lo=6. Issue 9*9 in the mult_done cycle -> accepted; hi/lo=6 held until the second mult_done, then lo=0x51.
- Reset mid-op: start 0x1234*0x10, assert reset at cycle 15 -> hi=lo=0, mult_busy=0, no mult_done. After release a new multu 2*2 gives lo=4 at normal latency.
- Operand change after accept: change srca/srcb/mult_sign every cycle during RUN -> result equals the product of the values sampled at accept.
